// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the register file, control unit and the
// multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             WrHi;
    logic             WrLo;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Op, A, B, WrHi, WrLo,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  Start, Op, A, B, WrHi, WrLo,
        output Busy, Done, HI, LO
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle on magnitudes, sign fix-up on commit into HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         CLK,
    input  logic         RST,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b10;

    state_t             state;
    logic [5:0]         cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               signed_op;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_cand;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign bus.Busy = (state != IDLE);
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

    assign signed_op = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
    assign a_abs     = (signed_op && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_abs     = (signed_op && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // Multiply keeps {partial product, remaining multiplier bits} in acc;
    // divide keeps {partial remainder, dividend bits becoming quotient bits}.
    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_cand = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_cand - {1'b0, opnd};
        step_acc = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (!div_diff[WIDTH]) step_acc = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  step_acc = {div_cand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Negating the magnitude quotient also yields the 0x80000000 / -1 wrap.
    assign prod_fix = neg_q ? -acc : acc;
    assign quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            opnd     <= '0;
            acc      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        is_div   <= bus.Op[1];
                        neg_q    <= signed_op && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        neg_r    <= signed_op && bus.A[WIDTH-1];
                        div_zero <= bus.Op[1] && (bus.B == '0);
                        a_raw    <= bus.A;
                        cnt      <= '0;
                        if (bus.Op[1]) begin
                            acc  <= {{WIDTH{1'b0}}, a_abs};
                            opnd <= b_abs;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, b_abs};
                            opnd <= a_abs;
                        end
                        state <= RUN;
                    end else begin
                        if (bus.WrHi) hi_q <= bus.A;
                        if (bus.WrLo) lo_q <= bus.A;
                    end
                end
                RUN: begin
                    acc <= step_acc;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        hi_q <= a_raw;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations
// compared against a plain-arithmetic model of the MIPS HI/LO results.
module tb_muldiv_unit;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if #(.WIDTH(WIDTH)) bus();

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint      sp;
        logic [63:0] up;
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                hi = sp[63:32];
                lo = sp[31:0];
            end
            2'b01: begin
                up = {32'h0, a} * {32'h0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            2'b10: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'h0;
                end else begin
                    lo = $signed(a) / $signed(b);
                    hi = $signed(a) % $signed(b);
                end
            end
            default: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Caller is just past a negedge; Start is sampled at the next posedge (edge t).
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        @(negedge clk);
        bus.Start = 1'b0;
        check("busy_after_start", 64'(bus.Busy), 64'd1);
    endtask

    // Returns the edge offset k at which Done is first seen (-1 on timeout) and
    // the number of cycles Busy was high. poke_at>0 drives Start+WrHi at edge t+poke_at+1.
    task automatic wait_result(input int poke_at, output int lat, output int busy_cycles);
        lat         = -1;
        busy_cycles = 1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.Done) begin
                lat = k;
                if (bus.Busy) busy_cycles++;
                break;
            end
            if (bus.Busy) busy_cycles++;
            if (k == poke_at) begin
                bus.Start = 1'b1;
                bus.Op    = 2'b11;
                bus.A     = 32'h0000_DEAD;
                bus.B     = 32'd3;
                bus.WrHi  = 1'b1;
            end
            if (k == poke_at + 1) begin
                bus.Start = 1'b0;
                bus.WrHi  = 1'b0;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int poke_at);
        int          lat;
        int          busy_cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        model(op, a, b, exp_hi, exp_lo);
        launch(op, a, b);
        wait_result(poke_at, lat, busy_cycles);
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
        check({tag, "_hi"}, 64'(bus.HI), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.LO), 64'(exp_lo));
    endtask

    initial begin
        int done_seen;
        bus.Start = 1'b0;
        bus.Op    = 2'b00;
        bus.A     = '0;
        bus.B     = '0;
        bus.WrHi  = 1'b0;
        bus.WrLo  = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("reset_hi", 64'(bus.HI), 64'd0);
        check("reset_lo", 64'(bus.LO), 64'd0);
        check("reset_busy", 64'(bus.Busy), 64'd0);
        check("reset_done", 64'(bus.Done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_check("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 0);
        check("mult_neg3x5_hi_value", 64'(bus.HI), 64'hFFFF_FFFF);
        check("mult_neg3x5_lo_value", 64'(bus.LO), 64'hFFFF_FFF1);
        @(negedge clk);
        check("done_single_pulse", 64'(bus.Done), 64'd0);

        // From here each launch happens in the Done cycle of the previous op.
        run_check("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max_hi_value", 64'(bus.HI), 64'hFFFF_FFFE);
        run_check("mult_m1xm1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_check("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_neg7by2_lo_value", 64'(bus.LO), 64'hFFFF_FFFD);
        run_check("divu_7by2", 2'b11, 32'd7, 32'd2, 0);
        run_check("divu_by_zero", 2'b11, 32'h1234_5678, 32'd0, 0);
        check("divu_by_zero_hi_value", 64'(bus.HI), 64'h1234_5678);
        run_check("div_by_zero", 2'b10, 32'h8765_4321, 32'd0, 0);
        run_check("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_overflow_lo_value", 64'(bus.LO), 64'h8000_0000);

        run_check("busy_window", 2'b01, 32'd2, 32'd3, 9);
        check("busy_window_lo_value", 64'(bus.LO), 64'd6);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.Done) done_seen++;
        end
        check("busy_window_no_second_done", 64'(done_seen), 64'd0);
        check("busy_window_hi_held", 64'(bus.HI), 64'd0);

        for (int i = 0; i < 20; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_check($sformatf("rand%0d_op%0d", i, op), op, a, b, 0);
        end

        @(negedge clk);
        bus.WrHi = 1'b1;
        bus.WrLo = 1'b1;
        bus.A    = 32'hCAFE_F00D;
        @(negedge clk);
        bus.WrHi = 1'b0;
        bus.WrLo = 1'b0;
        check("mthi_hi", 64'(bus.HI), 64'hCAFE_F00D);
        check("mtlo_lo", 64'(bus.LO), 64'hCAFE_F00D);

        launch(2'b00, 32'hFFFF_FFFD, 32'd5);
        for (int k = 1; k < 15; k++) @(negedge clk);
        check("pre_reset_busy", 64'(bus.Busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midop_reset_hi", 64'(bus.HI), 64'd0);
        check("midop_reset_lo", 64'(bus.LO), 64'd0);
        check("midop_reset_busy", 64'(bus.Busy), 64'd0);
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.Done) done_seen++;
        end
        check("midop_reset_no_done", 64'(done_seen), 64'd0);
        rst_n = 1'b1;
        run_check("after_reset_multu", 2'b01, 32'd4, 32'd4, 0);
        check("after_reset_lo_value", 64'(bus.LO), 64'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
